// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared state encoding and UART line constants for the FIFO drain stage
package fifo_uart_pkg;
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read-side handshake between the FIFO (slave) and its drain (master)
interface fifo_uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic fifo_rd;
  logic fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  modport master (output fifo_rd, input fifo_empty, fifo_rdata);
  modport slave (input fifo_rd, output fifo_empty, fifo_rdata);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: counts 0..CLKS_PER_BIT-1 while running, ticking at terminal count
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16,
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);
  logic [CW-1:0] cnt;
  assign tick = run && cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the FIFO and sends each as an 8N1 UART frame, LSB first
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  fifo_uart_tx_if.master fifo,
  output logic tx,
  output logic busy,
  output logic [7:0] frames_sent
);
  localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);
  state_t state;
  logic [DATA_WIDTH-1:0] shift;
  logic [2:0] bit_idx;
  logic tick;
  logic go;
  assign go = en && !fifo.fifo_empty;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst(rst),
    .clear(state == LOAD),
    .run(state inside {START, DATA, STOP}),
    .tick(tick)
  );
  // tx is registered on each transition so the line level always matches the state being entered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tx <= UART_IDLE_LEVEL;
      fifo.fifo_rd <= 1'b0;
      busy <= 1'b0;
      frames_sent <= '0;
      shift <= '0;
      bit_idx <= '0;
    end else begin
      fifo.fifo_rd <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state <= POP;
          fifo.fifo_rd <= 1'b1;
          busy <= 1'b1;
        end
        POP: state <= LOAD;
        LOAD: begin
          shift <= fifo.fifo_rdata;
          bit_idx <= '0;
          tx <= UART_START_LEVEL;
          state <= START;
        end
        START: if (tick) begin
          tx <= shift[0];
          state <= DATA;
        end
        DATA: if (tick) begin
          if (bit_idx == BIT_LAST) begin
            tx <= UART_IDLE_LEVEL;
            state <= STOP;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx <= shift[bit_idx + 1'b1];
          end
        end
        STOP: if (tick) begin
          frames_sent <= frames_sent + 1'b1;
          fifo.fifo_rd <= go;
          busy <= go;
          state <= go ? POP : IDLE;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          tx <= UART_IDLE_LEVEL;
        end
      endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: FIFO model plus UART receiver, checked against a byte scoreboard
module tb_fifo_uart_tx;
  localparam int C = 4;
  localparam int FRAME = 10 * C;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic tx, busy;
  logic [7:0] frames_sent;
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int starts[$];
  int pops = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  fifo_uart_tx_if #(.DATA_WIDTH(8)) fif();

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .fifo(fif.master),
    .tx(tx),
    .busy(busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(int n0);
    int t;
    t = 0;
    while (starts.size() == n0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("start_seen", 32'(starts.size() > n0), 32'd1);
  endtask

  // FIFO read side: data appears the cycle after the pop strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fif.fifo_rd === 1'b1) begin
      chk("rd_while_empty", 32'(fif.fifo_empty), 32'd0);
      pops <= pops + 1;
      if (fq.size() > 0) fif.fifo_rdata <= fq.pop_front();
    end
    fif.fifo_empty <= (fq.size() == 0);
  end

  // UART receiver: every cycle of each bit must hold the level seen on its first cycle
  initial begin
    logic prev;
    logic [9:0] fr;
    logic [7:0] e;
    bit ab, shape;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev === 1'b1 && tx === 1'b0) begin
        starts.push_back(cyc);
        fr = '0;
        ab = 0;
        shape = 0;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) ab = 1;
          if (k % C == 0) fr[k / C] = tx;
          else if (tx !== fr[k / C]) shape = 1;
        end
        if (ab) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
          e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
          chk("start_bit", 32'(fr[0]), 32'd0);
          chk("stop_bit", 32'(fr[9]), 32'd1);
          chk("bit_width", 32'(shape), 32'd0);
          chk("frame_data", 32'(fr[8:1]), 32'(e));
        end
      end
      prev = tx;
    end
  end

  initial begin
    int p0, n0, bc;
    logic [7:0] f0;
    push(8'hA5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_rd", 32'(fif.fifo_rd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frames", 32'(frames_sent), 32'd0);
    end
    rst = 1'b0;
    bc = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("single_busy_len", 32'(bc), 32'd42);
    chk("single_frames", 32'(frames_sent), 32'd1);
    chk("single_pops", 32'(pops), 32'd1);
    chk("single_idle", 32'(busy), 32'd0);

    p0 = pops;
    f0 = frames_sent;
    n0 = starts.size();
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    cycles(3 * (FRAME + 2) + 20);
    chk("b2b_frames", 32'(frames_sent), 32'(8'(f0 + 3)));
    chk("b2b_starts", 32'(starts.size()), 32'(n0 + 3));
    if (starts.size() >= n0 + 3) begin
      chk("b2b_gap1", 32'(starts[n0 + 1] - starts[n0]), 32'(FRAME + 2));
      chk("b2b_gap2", 32'(starts[n0 + 2] - starts[n0 + 1]), 32'(FRAME + 2));
    end
    cycles(20);
    chk("b2b_pops", 32'(pops - p0), 32'd3);
    chk("b2b_idle", 32'(busy), 32'd0);

    p0 = pops;
    f0 = frames_sent;
    n0 = starts.size();
    push(8'h5A);
    push(8'hC3);
    wait_start(n0);
    while (cyc < starts[$] + 4 * C + 1) @(negedge clk);
    en = 1'b0;
    cycles(60);
    chk("gate_pops", 32'(pops - p0), 32'd1);
    chk("gate_frames", 32'(frames_sent), 32'(8'(f0 + 1)));
    chk("gate_idle", 32'(busy), 32'd0);
    en = 1'b1;
    cycles(60);
    chk("ungate_pops", 32'(pops - p0), 32'd2);
    chk("ungate_frames", 32'(frames_sent), 32'(8'(f0 + 2)));

    p0 = pops;
    n0 = starts.size();
    push(8'h99);
    wait_start(n0);
    while (cyc < starts[$] + 6 * C + 1) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_frames", 32'(frames_sent), 32'd0);
    cycles(3);
    rst = 1'b0;
    cycles(60);
    chk("arst_after_tx", 32'(tx), 32'd1);
    chk("arst_after_busy", 32'(busy), 32'd0);
    chk("arst_after_frames", 32'(frames_sent), 32'd0);
    chk("arst_pops", 32'(pops - p0), 32'd1);

    p0 = pops;
    for (int i = 0; i < 257; i++) push(8'($urandom));
    cycles(257 * (FRAME + 2) + 60);
    chk("wrap_frames", 32'(frames_sent), 32'd1);
    chk("wrap_pops", 32'(pops - p0), 32'd257);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
